// File: rtl/apb_timer_slave.sv
// -----------------------------------------------------------------------------
// apb_timer_slave
//
// This is a zero-wait-state APB completer. It serves one PSEL line of the
// AHB-to-APB bridge. It holds a small register bank in front of a 32-bit
// down-counter timer:
//   0x00 CTRL    RW  [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN
//   0x01 LOAD    RW  reload value
//   0x02 COUNT   RW  read: live counter, write: load the counter directly
//   0x03 STATUS  W1C [0] EXPIRED, [1] PROT_ERR (both sticky)
//   0x04 SCRATCH RW  general purpose
//   0x05 ID      RO  ID_VALUE
//   0x06..       reads return 0 and writes are ignored
//
// The bus has no PREADY or PSLVERR, so every transfer is exactly SETUP+ACCESS.
// Read data is captured in the SETUP cycle. It then holds steady through
// ACCESS and afterwards.
//
// Ports:
//   HCLK     bus clock, rising edge
//   RESET    asynchronous, active-high reset
//   PSEL     slave select
//   PENABLE  access-phase indicator
//   PWRITE   1 = write, 0 = read
//   PADDR    word index (ADDR_W bits)
//   PWDATA   write data
//   PRDATA   registered read data
//   IRQ      level interrupt: STATUS.EXPIRED & CTRL.IRQ_EN, registered
// -----------------------------------------------------------------------------
module apb_timer_slave #(
    parameter logic [31:0] ID_VALUE = 32'hA9B0_0001,
    parameter int          ADDR_W   = 5
) (
    input  logic              HCLK,
    input  logic              RESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              IRQ
);

    localparam logic [ADDR_W-1:0] ADDR_CTRL    = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] ADDR_LOAD    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_COUNT   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] ADDR_STATUS  = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] ADDR_ID      = ADDR_W'(5);

    // Bit positions inside CTRL and STATUS
    localparam int CTRL_EN      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_IRQ_EN  = 2;
    localparam int STAT_EXPIRED = 0;
    localparam int STAT_PROT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;      // PADDR latched at SETUP
    logic                write_q, write_d;    // PWRITE latched at SETUP
    logic [2:0]          ctrl_q, ctrl_d;
    logic [31:0]         load_q, load_d;
    logic [31:0]         count_q, count_d;
    logic [1:0]          status_q, status_d;
    logic [31:0]         scratch_q, scratch_d;
    logic [31:0]         prdata_q, prdata_d;
    logic                irq_q, irq_d;

    // -------------------------------------------------------------------------
    // Bus-phase decode
    // -------------------------------------------------------------------------
    logic        setup_cyc;    // PSEL & !PENABLE: the bus SETUP phase
    logic        access_cyc;   // PSEL &  PENABLE: the bus ACCESS phase
    logic        commit;       // the single write strobe of a transfer
    logic        prot_err;     // hardware set of STATUS.PROT_ERR
    logic        exp_set;      // hardware set of STATUS.EXPIRED
    logic [31:0] rd_value;

    assign setup_cyc  = PSEL & ~PENABLE;
    assign access_cyc = PSEL &  PENABLE;

    // -------------------------------------------------------------------------
    // Protocol FSM: next state, write strobe and protocol-error detection
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of a combinational block gets a default first.
        // Without it, a path that skips the assignment would infer a latch.
        state_d  = state_q;
        commit   = 1'b0;
        prot_err = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (setup_cyc) begin
                    state_d = ST_SETUP;
                end else if (access_cyc) begin
                    // ACCESS with no preceding SETUP: flag it and stay idle.
                    prot_err = 1'b1;
                end
            end

            ST_SETUP: begin
                if (access_cyc) begin
                    state_d = ST_ACCESS;
                    // The address and direction must not move between phases.
                    // If they do, the transfer is dropped.
                    if ((PADDR != addr_q) || (PWRITE != write_q)) begin
                        prot_err = 1'b1;
                    end else begin
                        commit = PWRITE;
                    end
                end else if (!PSEL) begin
                    state_d = ST_IDLE;
                end
            end

            ST_ACCESS: begin
                // A stretched ACCESS stays here. Because the write strobe fires
                // only on the SETUP->ACCESS edge, it cannot fire again.
                if (setup_cyc) begin
                    state_d = ST_SETUP;
                end else if (access_cyc) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // SETUP qualifiers are relatched on every SETUP cycle
    assign addr_d  = setup_cyc ? PADDR  : addr_q;
    assign write_d = setup_cyc ? PWRITE : write_q;

    // -------------------------------------------------------------------------
    // Read mux
    // -------------------------------------------------------------------------
    always_comb begin
        rd_value = 32'd0;
        case (PADDR)
            ADDR_CTRL:    rd_value = {29'd0, ctrl_q};
            ADDR_LOAD:    rd_value = load_q;
            ADDR_COUNT:   rd_value = count_q;
            ADDR_STATUS:  rd_value = {30'd0, status_q};
            ADDR_SCRATCH: rd_value = scratch_q;
            ADDR_ID:      rd_value = ID_VALUE;
            default:      rd_value = 32'd0;
        endcase
    end

    // Capture in SETUP so that PRDATA is already stable for the whole ACCESS
    assign prdata_d = (setup_cyc && !PWRITE) ? rd_value : prdata_q;

    // -------------------------------------------------------------------------
    // Register bank and timer
    // -------------------------------------------------------------------------
    logic wr_ctrl, wr_load, wr_count, wr_status, wr_scratch;

    assign wr_ctrl    = commit && (PADDR == ADDR_CTRL);
    assign wr_load    = commit && (PADDR == ADDR_LOAD);
    assign wr_count   = commit && (PADDR == ADDR_COUNT);
    assign wr_status  = commit && (PADDR == ADDR_STATUS);
    assign wr_scratch = commit && (PADDR == ADDR_SCRATCH);

    always_comb begin
        ctrl_d  = ctrl_q;
        count_d = count_q;
        exp_set = 1'b0;

        // Timer step. It only moves while EN is set. Zero is terminal:
        // the counter never wraps below zero.
        if (ctrl_q[CTRL_EN]) begin
            if (count_q != 32'd0) begin
                count_d = count_q - 32'd1;
            end else begin
                exp_set = 1'b1;
                if (ctrl_q[CTRL_AUTO]) begin
                    count_d = load_q;
                end else begin
                    ctrl_d[CTRL_EN] = 1'b0;
                end
            end
        end

        // Software writes are applied last, so they win over the timer on the
        // same edge.
        if (wr_ctrl) begin
            ctrl_d = PWDATA[2:0];
        end
        if (wr_count) begin
            count_d = PWDATA;
        end
    end

    assign load_d    = wr_load    ? PWDATA : load_q;
    assign scratch_d = wr_scratch ? PWDATA : scratch_q;

    // W1C is applied first, then the hardware sets, so a set on the same edge
    // survives the clear.
    always_comb begin
        status_d = status_q;
        if (wr_status) begin
            status_d = status_q & ~PWDATA[1:0];
        end
        if (exp_set) begin
            status_d[STAT_EXPIRED] = 1'b1;
        end
        if (prot_err) begin
            status_d[STAT_PROT] = 1'b1;
        end
    end

    // IRQ comes from flops, so it follows EXPIRED by one cycle
    assign irq_d = status_q[STAT_EXPIRED] & ctrl_q[CTRL_IRQ_EN];

    // -------------------------------------------------------------------------
    // Sequential state
    // -------------------------------------------------------------------------
    // NOTE: every flop here is reset, including the data registers. This is a
    // small register bank rather than a memory array, so software always
    // reads a defined value after RESET.
    always_ff @(posedge HCLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            write_q   <= 1'b0;
            ctrl_q    <= '0;
            load_q    <= '0;
            count_q   <= '0;
            status_q  <= '0;
            scratch_q <= '0;
            prdata_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments. All flops
            // then update together from pre-edge values, with no ordering
            // races.
            state_q   <= state_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            ctrl_q    <= ctrl_d;
            load_q    <= load_d;
            count_q   <= count_d;
            status_q  <= status_d;
            scratch_q <= scratch_d;
            prdata_q  <= prdata_d;
            irq_q     <= irq_d;
        end
    end

    assign PRDATA = prdata_q;
    assign IRQ    = irq_q;

endmodule

// File: tb/tb_apb_timer_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_timer_slave
//
// Directed-vector bench for apb_timer_slave.
//
// The stimulus tasks drive APB transfers. Each task pushes its hand-computed
// expected PRDATA (and optionally IRQ) into a queue. An independent monitor
// pops and compares on each falling edge where obs_stb marks a valid read
// ACCESS cycle.
//
// Inputs change 1 ns after the rising edge. Outputs are sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_apb_timer_slave;

    localparam logic [31:0] ID = 32'hA9B0_0001;

    localparam logic [4:0] A_CTRL    = 5'h00;
    localparam logic [4:0] A_LOAD    = 5'h01;
    localparam logic [4:0] A_COUNT   = 5'h02;
    localparam logic [4:0] A_STATUS  = 5'h03;
    localparam logic [4:0] A_SCRATCH = 5'h04;
    localparam logic [4:0] A_ID      = 5'h05;

    logic        HCLK = 1'b0;
    logic        RESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [4:0]  PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        IRQ;

    always #5 HCLK = ~HCLK;

    apb_timer_slave #(
        .ID_VALUE (ID),
        .ADDR_W   (5)
    ) dut (
        .HCLK    (HCLK),
        .RESET   (RESET),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .IRQ     (IRQ)
    );

    // -------------------------------------------------------------------------
    // Scoreboard
    // -------------------------------------------------------------------------
    typedef struct {
        string       name;
        logic [31:0] data;
        bit          chk_irq;
        logic        irq;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;
    logic obs_stb  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge HCLK) begin
        if (obs_stb) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_underflow: got an observation, expected none");
            end else begin
                mon_e = exp_q.pop_front();
                check(mon_e.name, PRDATA, mon_e.data);
                if (mon_e.chk_irq) begin
                    check({mon_e.name, "_irq"}, {31'd0, IRQ}, {31'd0, mon_e.irq});
                end
            end
        end
    end

    task automatic push_exp(input string n, input logic [31:0] d, input bit ci, input logic irq);
        exp_t e;
        e.name    = n;
        e.data    = d;
        e.chk_irq = ci;
        e.irq     = irq;
        exp_q.push_back(e);
    endtask

    // -------------------------------------------------------------------------
    // Bus tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle(input int n);
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        repeat (n) tick();
    endtask

    // The write commits on the second rising edge after the call. The task
    // leaves the bus in ACCESS, so the next task can run back-to-back.
    task automatic apb_write(input logic [4:0] a, input logic [31:0] d);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = a;
        PWDATA  = d;
        tick();
        PENABLE = 1'b1;
        tick();
    endtask

    // PRDATA is captured on the first rising edge after the call. It is then
    // observed during ACCESS.
    task automatic apb_read(input logic [4:0] a, input string n, input logic [31:0] d,
                            input bit ci, input logic irq);
        push_exp(n, d, ci, irq);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = a;
        tick();
        PENABLE = 1'b1;
        obs_stb = 1'b1;
        tick();
        obs_stb = 1'b0;
    endtask

    // Observe PRDATA/IRQ without a bus transfer
    task automatic observe(input string n, input logic [31:0] d, input logic irq);
        push_exp(n, d, 1'b1, irq);
        obs_stb = 1'b1;
        tick();
        obs_stb = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin
        RESET   = 1'b1;
        PSEL    = 1'b0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = '0;
        repeat (2) tick();
        observe("reset_prdata", 32'd0, 1'b0);
        RESET = 1'b0;
        idle(1);

        // Reset values and ID
        apb_read(A_ID,      "rd_id",          ID,    1'b1, 1'b0);
        apb_read(A_CTRL,    "rst_ctrl",       32'd0, 1'b0, 1'b0);
        apb_read(A_LOAD,    "rst_load",       32'd0, 1'b0, 1'b0);
        apb_read(A_COUNT,   "rst_count",      32'd0, 1'b0, 1'b0);
        apb_read(A_STATUS,  "rst_status",     32'd0, 1'b0, 1'b0);
        apb_read(A_SCRATCH, "rst_scratch",    32'd0, 1'b1, 1'b0);

        // Scratch read back-to-back with the write, then unmapped words
        apb_write(A_SCRATCH, 32'hDEAD_BEEF);
        apb_read(A_SCRATCH, "scratch_b2b",    32'hDEAD_BEEF, 1'b0, 1'b0);
        apb_write(5'h1F, 32'hFFFF_FFFF);
        apb_read(5'h1F,     "unmapped_1f",    32'd0, 1'b0, 1'b0);
        apb_read(5'h06,     "unmapped_06",    32'd0, 1'b0, 1'b0);
        apb_read(A_SCRATCH, "scratch_kept",   32'hDEAD_BEEF, 1'b0, 1'b0);
        idle(1);

        // One-shot, run A. EN=1 after edge E0. EXPIRED is set on E4 and IRQ
        // rises on E5. This read captures on E4, so it still sees 0.
        apb_write(A_LOAD,  32'd3);
        apb_write(A_COUNT, 32'd3);
        apb_write(A_CTRL,  32'h5);
        idle(3);
        apb_read(A_STATUS,  "os_status_e4",   32'd0, 1'b1, 1'b0);
        apb_read(A_STATUS,  "os_status_e6",   32'd1, 1'b1, 1'b1);
        apb_read(A_CTRL,    "os_ctrl_en_clr", 32'h4, 1'b1, 1'b1);
        apb_read(A_COUNT,   "os_count_zero",  32'd0, 1'b0, 1'b0);
        apb_read(A_LOAD,    "os_load",        32'd3, 1'b0, 1'b0);
        apb_write(A_STATUS, 32'd1);
        idle(2);
        apb_read(A_STATUS,  "os_cleared",     32'd0, 1'b1, 1'b0);

        // One-shot, run B. This read captures on E5, so EXPIRED is already
        // set. IRQ is high during its ACCESS.
        apb_write(A_COUNT, 32'd3);
        apb_write(A_CTRL,  32'h5);
        idle(4);
        apb_read(A_STATUS,  "os_status_e5",   32'd1, 1'b1, 1'b1);
        apb_write(A_CTRL,   32'h0);
        apb_write(A_STATUS, 32'd1);
        idle(1);

        // Auto-reload with LOAD=2. Expiries fall on E3, E6, E9, E12, E15...
        apb_write(A_LOAD,  32'd2);
        apb_write(A_COUNT, 32'd2);
        apb_write(A_CTRL,  32'h3);
        idle(4);
        apb_write(A_STATUS, 32'd1);                               // commits on E6
        apb_read(A_STATUS,  "ar_set_wins",    32'd1, 1'b0, 1'b0);  // capture E7
        apb_write(A_STATUS, 32'd1);                               // commits on E10
        apb_read(A_STATUS,  "ar_w1c_clears",  32'd0, 1'b0, 1'b0);  // capture E11
        apb_read(A_COUNT,   "ar_reloaded",    32'd2, 1'b0, 1'b0);  // capture E13
        apb_read(A_STATUS,  "ar_reexpired",   32'd1, 1'b0, 1'b0);  // capture E15
        apb_read(A_COUNT,   "ar_count_e17",   32'd1, 1'b0, 1'b0);  // capture E17
        apb_write(A_CTRL,   32'h0);
        apb_write(A_STATUS, 32'd1);
        apb_read(A_STATUS,  "ar_stopped",     32'd0, 1'b0, 1'b0);
        idle(1);

        // Protocol error: ACCESS with no SETUP
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PWRITE  = 1'b1;
        PADDR   = A_SCRATCH;
        PWDATA  = 32'h1234_5678;
        tick();
        idle(1);
        apb_read(A_STATUS,  "pe_nosetup",     32'd2, 1'b0, 1'b0);
        apb_read(A_SCRATCH, "pe_nosetup_scr", 32'hDEAD_BEEF, 1'b0, 1'b0);
        apb_write(A_STATUS, 32'd2);
        apb_read(A_STATUS,  "pe_cleared",     32'd0, 1'b0, 1'b0);
        idle(1);

        // Protocol error: PADDR changes 0x04 -> 0x01 between SETUP and ACCESS
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = A_SCRATCH;
        PWDATA  = 32'h5555_AAAA;
        tick();
        PENABLE = 1'b1;
        PADDR   = A_LOAD;
        tick();
        idle(1);
        apb_read(A_STATUS,  "pe_addr",        32'd2, 1'b0, 1'b0);
        apb_read(A_SCRATCH, "pe_addr_scr",    32'hDEAD_BEEF, 1'b0, 1'b0);
        apb_read(A_LOAD,    "pe_addr_load",   32'd2, 1'b0, 1'b0);
        apb_write(A_STATUS, 32'd2);
        idle(1);

        // PENABLE held for 3 cycles. PWDATA changes after the commit edge,
        // so a second commit would be visible.
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = A_SCRATCH;
        PWDATA  = 32'hC0FF_EE01;
        tick();
        PENABLE = 1'b1;
        tick();
        PWDATA  = 32'hBAD0_BAD0;
        tick();
        tick();
        idle(1);
        apb_read(A_SCRATCH, "hold_single",    32'hC0FF_EE01, 1'b0, 1'b0);
        apb_read(A_STATUS,  "hold_no_err",    32'd0, 1'b0, 1'b0);
        idle(1);

        // RESET during the ACCESS of a COUNT write while the timer runs
        apb_write(A_SCRATCH, 32'h1357_9BDF);
        apb_write(A_LOAD,    32'd100);
        apb_write(A_COUNT,   32'd100);
        apb_write(A_CTRL,    32'h3);
        apb_read(A_SCRATCH, "pre_rst_scr",    32'h1357_9BDF, 1'b0, 1'b0);
        idle(2);
        PSEL    = 1'b1;
        PENABLE = 1'b0;
        PWRITE  = 1'b1;
        PADDR   = A_COUNT;
        PWDATA  = 32'd50;
        tick();
        PENABLE = 1'b1;
        #2;
        RESET   = 1'b1;
        tick();
        idle(1);
        RESET   = 1'b0;
        observe("rst2_prdata", 32'd0, 1'b0);
        apb_read(A_CTRL,    "rst2_ctrl",      32'd0, 1'b0, 1'b0);
        apb_read(A_LOAD,    "rst2_load",      32'd0, 1'b0, 1'b0);
        apb_read(A_COUNT,   "rst2_count",     32'd0, 1'b0, 1'b0);
        apb_read(A_STATUS,  "rst2_status",    32'd0, 1'b0, 1'b0);
        apb_read(A_SCRATCH, "rst2_scratch",   32'd0, 1'b1, 1'b0);
        idle(1);
        apb_read(A_ID,      "rst2_id",        ID,    1'b0, 1'b0);
        idle(2);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net so the run can never hang
    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog: got no end of stimulus, expected completion before 200000 ns");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/apb_timer_slave.md
Name: apb_timer_slave

Overview:
- APB completer (responder) sitting on one PSEL line of the AHB-to-APB bridge's 4-way PSEL decoder.
- Provides a zero-wait-state register bank: control, reload, down-counter, sticky status, scratch and ID.
- Drives an interrupt to the system.
- The bus has no PREADY/PSLVERR, so every transfer completes in SETUP+ACCESS and read data must be stable for the whole ACCESS cycle.

Parameters:
- ID_VALUE, 32'hA9B0_0001, constant returned at word 0x05.
- ADDR_W, 5, PADDR width, matches the bridge's PADDR.

Ports:
- HCLK  in  1  single clock, rising edge; the APB side runs on the bus clock.
- RESET  in  1  asynchronous, active-high reset.
- PSEL  in  1  this slave's select line (one bit of the bridge's PSEL[3:0]).
- PENABLE  in  1  APB access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  ADDR_W  word index.
- PWDATA  in  32  write data.
- PRDATA  out  32  read data, registered.
- IRQ  out  1  interrupt, level, active-high.

Behaviour:
- Reset (async, RESET=1): all registers 0, FSM to IDLE, PRDATA=0, IRQ=0.
- Protocol FSM:
  - IDLE -> SETUP on PSEL & !PENABLE.
  - SETUP -> ACCESS on PSEL & PENABLE; latch PADDR/PWRITE at SETUP.
  - SETUP -> IDLE on !PSEL.
  - ACCESS -> SETUP on PSEL & !PENABLE (back-to-back); ACCESS -> ACCESS if PSEL & PENABLE persists; ACCESS -> IDLE otherwise.
- Protocol error: PSEL & PENABLE seen in IDLE, or PADDR/PWRITE at ACCESS differing from the SETUP latch, sets STATUS.PROT_ERR. No register commit for that transfer.
- Write commit: exactly once per transfer, at the SETUP->ACCESS edge with PWRITE=1, using PADDR/PWDATA of that cycle. Extra PENABLE cycles while in ACCESS never commit again.
- Read capture: on the edge where PSEL & !PENABLE & !PWRITE, PRDATA <= value(PADDR). PRDATA holds until the next read SETUP, so it is valid for the whole ACCESS cycle and after it.
- Register map (word index):
  - 0x00 CTRL RW: [0] EN, [1] AUTO_RELOAD, [2] IRQ_EN; other bits read 0.
  - 0x01 LOAD RW, 32-bit.
  - 0x02 COUNT: read = current counter; write = load counter directly.
  - 0x03 STATUS: [0] EXPIRED, [1] PROT_ERR. Both sticky; write-1-to-clear; writing 0 has no effect.
  - 0x04 SCRATCH RW, 32-bit.
  - 0x05 ID RO = ID_VALUE.
  - 0x06–0x1F: read 0, writes ignored (no error).
- Timer, per cycle while EN=1:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: set EXPIRED. If AUTO_RELOAD, COUNT <= LOAD; else EN <= 0 and COUNT stays 0.
- Timer while EN=0: COUNT frozen.
- Expiry period with AUTO_RELOAD is LOAD+1 cycles.
- Precedence, same edge:
  - Software write to COUNT beats decrement or reload.
  - Software write to CTRL beats the one-shot EN clear.
  - Hardware set of EXPIRED/PROT_ERR beats W1C.
- IRQ = STATUS.EXPIRED & CTRL.IRQ_EN, taken from flops; it rises the cycle after EXPIRED is set.
- Unsigned arithmetic, no underflow: COUNT never goes below 0.
- Reset mid-transfer: FSM returns to IDLE immediately and the transfer is dropped. The next SETUP is handled normally.

Test Plan:
- Reset then read ID (SETUP addr 0x05, ACCESS) -> PRDATA=32'hA9B0_0001 during ACCESS; reads of CTRL, LOAD, COUNT, STATUS, SCRATCH return 0.
- Write SCRATCH=32'hDEAD_BEEF, then read back-to-back (write ACCESS followed immediately by read SETUP) -> PRDATA=32'hDEAD_BEEF. A write to 0x1F reads back 0.
- One-shot: LOAD=3, COUNT=3, CTRL=0b101 -> EXPIRED set 4 cycles after EN=1 and IRQ=1 one cycle later; EN reads 0; COUNT holds 0.
- Auto-reload: LOAD=2, COUNT=2, CTRL=0b011 -> EXPIRED asserted every 3 cycles. Write STATUS=1 on the expiry edge -> EXPIRED stays 1 (set wins). Write STATUS=1 on a non-expiry edge -> EXPIRED clears.
- Protocol errors: PENABLE=1 with no SETUP -> PROT_ERR=1 and no write committed. PADDR changed 0x04->0x01 between SETUP and ACCESS -> PROT_ERR=1 and neither SCRATCH nor LOAD changes. PENABLE held 3 cycles on a SCRATCH write -> single commit.
- Assert RESET during the ACCESS of a COUNT write with the timer running -> all registers and PRDATA read 0 after release. A following normal read of ID succeeds.
